// File: rtl/rat_pkg.sv
// Shared types for the interrupt/flag sequencer: FSM states and synchronizer depth.
package rat_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ENTRY  = 2'd1,
    ISR    = 2'd2,
    RETURN = 2'd3
  } state_t;

  localparam int SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/intr_sync.sv
// Multi-flop synchronizer plus rising-edge detect for an asynchronous level input.
// Latency SYNC_STAGES cycles to EDGE_OUT; no backpressure, EDGE_OUT is a single-cycle pulse.
module intr_sync
  import rat_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic CLK,
  input  logic RST,
  input  logic ASYNC_IN,
  output logic EDGE_OUT
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q[0] <= ASYNC_IN;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign EDGE_OUT = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/int_flag_seq.sv
// Interrupt entry/return sequencer driving flag-register controls; INT_TAKEN 1 cycle after qualify.
// No backpressure: CPU_READY gates entry, pending edges are held in PEND until taken.
module int_flag_seq
  import rat_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic CLK,
  input  logic RST,
  input  logic INTR,
  input  logic CPU_READY,
  input  logic SEI,
  input  logic CLI,
  input  logic RETIE,
  output logic INT_TAKEN,
  output logic FLG_SHAD_LD,
  output logic FLG_LD_SEL,
  output logic FLG_C_LD,
  output logic FLG_Z_LD,
  output logic I_FLAG,
  output logic IN_ISR,
  output logic RETIE_ERR
);

  state_t state_q, state_nxt;
  logic   pend_q, pend_nxt;
  logic   i_flag_q, i_flag_nxt;
  logic   retie_err_q;
  logic   intr_edge;

  intr_sync #(.SYNC_STAGES(SYNC_STAGES)) u_intr_sync (
    .CLK      (CLK),
    .RST      (RST),
    .ASYNC_IN (INTR),
    .EDGE_OUT (intr_edge)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      pend_q      <= 1'b0;
      i_flag_q    <= 1'b0;
      retie_err_q <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      pend_q      <= pend_nxt;
      i_flag_q    <= i_flag_nxt;
      retie_err_q <= RETIE && (state_q != ISR);
    end
  end

  always_comb begin
    state_nxt   = state_q;
    pend_nxt    = pend_q;
    i_flag_nxt  = i_flag_q;
    INT_TAKEN   = 1'b0;
    FLG_SHAD_LD = 1'b0;
    FLG_LD_SEL  = 1'b0;
    FLG_C_LD    = 1'b0;
    FLG_Z_LD    = 1'b0;
    case (state_q)
      IDLE: begin
        // Entry takes priority over SEI/CLI; CLI beats SEI.
        if (pend_q && i_flag_q && CPU_READY) begin
          state_nxt = ENTRY;
        end else if (CLI) begin
          i_flag_nxt = 1'b0;
        end else if (SEI) begin
          i_flag_nxt = 1'b1;
        end
      end
      ENTRY: begin
        INT_TAKEN   = 1'b1;
        FLG_SHAD_LD = 1'b1;
        i_flag_nxt  = 1'b0;
        pend_nxt    = 1'b0;
        state_nxt   = ISR;
      end
      ISR: begin
        if (RETIE) begin
          state_nxt = RETURN;
        end
      end
      RETURN: begin
        FLG_LD_SEL = 1'b1;
        FLG_C_LD   = 1'b1;
        FLG_Z_LD   = 1'b1;
        i_flag_nxt = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // A fresh edge always wins over the clear in ENTRY.
    if (intr_edge) begin
      pend_nxt = 1'b1;
    end
  end

  assign I_FLAG    = i_flag_q;
  assign IN_ISR    = (state_q != IDLE);
  assign RETIE_ERR = retie_err_q;

endmodule

// File: doc/int_flag_seq.md
INT_FLAG_SEQ -- requirements
Module: int_flag_seq

Interface
REQ-001 SHALL declare the parameter SYNC_STAGES, default 2, as the number of synchronizer flops on INTR.
REQ-002 SHALL have the port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have the port RST, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have the port INTR, input, 1 bit: external interrupt request, asynchronous level.
REQ-005 SHALL have the port CPU_READY, input, 1 bit: the control unit is at an instruction boundary this cycle.
REQ-006 SHALL have the port SEI, input, 1 bit: one-cycle pulse that enables interrupts.
REQ-007 SHALL have the port CLI, input, 1 bit: one-cycle pulse that disables interrupts.
REQ-008 SHALL have the port RETIE, input, 1 bit: one-cycle pulse marking a return-from-interrupt.
REQ-009 SHALL have the port INT_TAKEN, output, 1 bit: one-cycle pulse telling the control unit to vector the PC.
REQ-010 SHALL have the ports FLG_SHAD_LD, FLG_LD_SEL, FLG_C_LD and FLG_Z_LD, outputs, 1 bit each: controls driven to the flag register.
REQ-011 SHALL have the port I_FLAG, output, 1 bit: interrupt enable.
REQ-012 SHALL have the port IN_ISR, output, 1 bit: high while a service routine is active.
REQ-013 SHALL have the port RETIE_ERR, output, 1 bit: one-cycle pulse when RETIE is ignored.

Function
REQ-014 SHALL pass INTR through SYNC_STAGES flops and detect a rising edge on the synchronized value.
REQ-015 SHALL set PEND on a detected edge and clear PEND only in the ENTRY state; when both occur in one cycle, set wins.
REQ-016 SHALL implement the states IDLE, ENTRY, ISR and RETURN.
REQ-017 SHALL move IDLE->ENTRY when PEND=1, I_FLAG=1 and CPU_READY=1 in the same cycle; otherwise stay in IDLE.
REQ-018 SHALL hold ENTRY for exactly one cycle, asserting INT_TAKEN=1 and FLG_SHAD_LD=1, clearing I_FLAG at the end of the cycle, then moving to ISR.
REQ-019 SHALL stay in ISR until RETIE=1, then move to RETURN.
REQ-020 SHALL hold RETURN for exactly one cycle, asserting FLG_LD_SEL=1, FLG_C_LD=1 and FLG_Z_LD=1, setting I_FLAG=1 at the end of the cycle, then moving to IDLE.
REQ-021 SHALL drive every FLG_* output and INT_TAKEN as a Moore decode of the state; all are 0 in IDLE and in ISR.
REQ-022 SHALL drive IN_ISR=1 in ENTRY, ISR and RETURN.
REQ-023 SHALL give an interrupt latency of exactly 1 cycle from the qualifying IDLE cycle to INT_TAKEN.
REQ-024 SHALL, in IDLE, apply SEI by setting I_FLAG=1 and CLI by setting I_FLAG=0; when both are present in one cycle, CLI wins.
REQ-025 SHALL ignore SEI and CLI in ENTRY, ISR and RETURN; no nesting is supported.
REQ-026 SHALL, on RETIE outside ISR, leave the state unchanged and pulse RETIE_ERR=1 for one cycle.
REQ-027 SHALL keep PEND set when an edge arrives during ISR, so that the interrupt is taken after RETURN on the first qualifying IDLE cycle.
REQ-028 SHALL, in IDLE with PEND=1 and I_FLAG=0, hold PEND indefinitely and fire once SEI sets I_FLAG.
REQ-029 SHALL give the state transition priority over SEI/CLI when SEI or CLI arrives in the same cycle as the IDLE->ENTRY qualification.

Reset
REQ-030 SHALL, on RST=1 at a rising CLK edge, set the state to IDLE, PEND=0, I_FLAG=0 and all synchronizer flops and the edge register to 0.
REQ-031 SHALL drive all outputs to 0 in the cycle after reset.
REQ-032 SHALL have RST override every other input, including mid-ENTRY, mid-ISR and mid-RETURN, and emit no further FLG_* pulse from the aborted sequence.

Structure
REQ-033 SHALL place the state enum typedef (IDLE, ENTRY, ISR, RETURN) and the SYNC_STAGES default in the shared package rat_pkg.
REQ-034 SHALL implement the synchronizer and rising-edge detector as the single sub-module intr_sync, with ports CLK, RST, ASYNC_IN and EDGE_OUT.

Verification
REQ-035 SHALL cover: reset, then SEI, then INTR held high with CPU_READY=1 -> INT_TAKEN and FLG_SHAD_LD both high exactly 1 cycle at SYNC_STAGES+2 cycles after INTR rises; I_FLAG=0 after.
REQ-036 SHALL cover: in ISR, RETIE pulse -> next cycle FLG_LD_SEL=FLG_C_LD=FLG_Z_LD=1 for 1 cycle; I_FLAG=1 and IN_ISR=0 the cycle after.
REQ-037 SHALL cover: I_FLAG=0 with one INTR edge -> no INT_TAKEN for 50 cycles; SEI -> INT_TAKEN 2 cycles later.
REQ-038 SHALL cover: second INTR edge during ISR -> after RETIE, RETURN, then INT_TAKEN on the next IDLE cycle with CPU_READY=1.
REQ-039 SHALL cover: RETIE in IDLE -> RETIE_ERR=1 for 1 cycle, state stays IDLE; SEI and CLI in the same cycle -> I_FLAG=0.
REQ-040 SHALL cover: RST asserted during ENTRY -> next cycle all outputs 0, PEND=0, state IDLE.
